i2s_adc_receiver: RTL and testbench

- Receive-side counterpart of the I2S DAC path: deserialises the codec ADC stream (AUD_ADCDAT) into 16-bit left/right sample pairs.
- Runs on CLOCK_50 and oversamples the externally generated AUD_BCLK and AUD_ADCLRCK.
- Presents each completed stereo pair through a one-deep ready/valid output register to downstream logic (recorder, level meter, loopback).

---
 rtl/i2s_adc_receiver_if.sv | 21 ++
 rtl/i2s_adc_receiver.sv | 146 ++++++++++++++
 tb/tb_i2s_adc_receiver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_receiver_if.sv
// Stereo sample output bus: one-deep ready/valid pair plus sticky overrun flag.
interface i2s_adc_receiver_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  overrun;
  logic                  clear_overrun;

  modport master (
    output left_data, right_data, sample_valid, overrun,
    input  sample_ready, clear_overrun
  );

  modport slave (
    input  left_data, right_data, sample_valid, overrun,
    output sample_ready, clear_overrun
  );
endinterface

// File: rtl/i2s_adc_receiver.sv
// I2S ADC deserialiser: oversamples BCLK/LRCK/DAT on CLOCK_50 and emits
// 16-bit left/right pairs through a one-deep ready/valid register.
module i2s_adc_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  i2s_adc_receiver_if.master bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ST_ALIGN, ST_SHIFT, ST_WAIT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
  logic                   bclk_p1;
  logic                   strobe, lrck_s, dat_s, lrck_chg;
  state_t                 state, state_n;
  logic [CNT_W-1:0]       count, count_n;
  logic                   chan, chan_n;
  logic                   lrck_last, lrck_last_n;
  logic [DATA_WIDTH-1:0]  left_sr, left_n, right_sr, right_n;
  logic                   pair_done, pair_done_n;
  logic                   load;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic d);
    return {w[DATA_WIDTH-2:0], d};
  endfunction

  // Short slot: the n captured bits sit in the LSBs; move them to the top, zero-fill below.
  function automatic logic [DATA_WIDTH-1:0] left_justify(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [CNT_W-1:0] n);
    return w << (CNT_W'(DATA_WIDTH) - n);
  endfunction

  // Synchroniser chains share depth so LRCK/DAT stay aligned with the BCLK edge
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_p1   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_p1   <= bclk_sync[SYNC_STAGES-1];
    end
  end

  assign strobe   = bclk_sync[SYNC_STAGES-1] & ~bclk_p1;
  assign lrck_s   = lrck_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign lrck_chg = strobe & (lrck_s != lrck_last);

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state     <= ST_ALIGN;
      count     <= '0;
      chan      <= 1'b0;
      lrck_last <= 1'b0;
      left_sr   <= '0;
      right_sr  <= '0;
      pair_done <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      chan      <= chan_n;
      lrck_last <= lrck_last_n;
      left_sr   <= left_n;
      right_sr  <= right_n;
      pair_done <= pair_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    chan_n      = chan;
    lrck_last_n = strobe ? lrck_s : lrck_last;
    left_n      = left_sr;
    right_n     = right_sr;
    pair_done_n = 1'b0;
    case (state)
      ST_ALIGN: begin
        if (lrck_chg && !lrck_s) begin
          state_n = ST_SHIFT;
          chan_n  = 1'b0;
          count_n = '0;
        end
      end
      ST_SHIFT: begin
        if (lrck_chg) begin
          // Word cut short: finish it now and use this strobe as the next delay slot
          if (chan) right_n = left_justify(right_sr, count);
          else      left_n  = left_justify(left_sr, count);
          pair_done_n = chan;
          chan_n      = lrck_s;
          count_n     = '0;
        end else if (strobe) begin
          if (chan) right_n = shift_in(right_sr, dat_s);
          else      left_n  = shift_in(left_sr, dat_s);
          count_n = count + 1'b1;
          if (count == CNT_W'(DATA_WIDTH - 1)) begin
            state_n     = ST_WAIT;
            pair_done_n = chan;
          end
        end
      end
      ST_WAIT: begin
        if (lrck_chg) begin
          state_n = ST_SHIFT;
          chan_n  = lrck_s;
          count_n = '0;
        end
      end
      default: state_n = ST_ALIGN;
    endcase
  end

  assign load = pair_done & (~bus.sample_valid | bus.sample_ready);

  // Output register: a pair arriving while the held one is unaccepted is dropped
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      bus.left_data    <= '0;
      bus.right_data   <= '0;
      bus.sample_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      if (load) begin
        bus.left_data    <= left_sr;
        bus.right_data   <= right_sr;
        bus.sample_valid <= 1'b1;
      end else if (bus.sample_ready) begin
        bus.sample_valid <= 1'b0;
      end
      if (pair_done && !load)     bus.overrun <= 1'b1;
      else if (bus.clear_overrun) bus.overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: drives I2S frames at CLOCK_50/8 and scores delivered pairs.
module tb_i2s_adc_receiver;
  logic CLOCK_50 = 1'b0;
  logic RST, AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;
  int   checks = 0;
  int   errors = 0;
  bit   found;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] l, r;

  i2s_adc_receiver_if #(.DATA_WIDTH(16)) bus ();

  i2s_adc_receiver #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .CLOCK_50    (CLOCK_50),
    .RST         (RST),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .bus         (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Every accepted handshake (valid & ready before the rising edge) is one delivered pair
  always @(negedge CLOCK_50)
    if (RST && bus.sample_valid && bus.sample_ready)
      got_q.push_back({bus.left_data, bus.right_data});

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n-bit word received in an n-bit slot ends up MSB-aligned in 16 bits
  function automatic logic [15:0] just(input logic [15:0] w, input int n);
    return 16'(w * (1 << (16 - n)));
  endfunction

  task automatic expect_pair(input logic [15:0] lw, input logic [15:0] rw, input int n);
    exp_q.push_back({just(lw, n), just(rw, n)});
  endtask

  task automatic check_pairs(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_pair"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic bclk_cycle(input logic lr, input logic d);
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    #80 AUD_BCLK = 1'b1;
    #80 AUD_BCLK = 1'b0;
  endtask

  // One channel slot: delay bit, then nbits MSB-first, then fill up to slot length
  task automatic send_chan(input logic lr, input logic [15:0] w, input int nbits,
                           input int slot, input logic fill);
    for (int i = 0; i < slot; i++) begin
      logic d;
      if (i == 0 || i > nbits) d = fill;
      else                     d = w[nbits-i];
      bclk_cycle(lr, d);
    end
  endtask

  task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw, input int nbits,
                            input int slot, input logic fill);
    send_chan(1'b0, lw, nbits, slot, fill);
    send_chan(1'b1, rw, nbits, slot, fill);
  endtask

  task automatic set_ready(input logic v);
    @(posedge CLOCK_50);
    #2 bus.sample_ready = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  initial begin
    RST = 1'b0;
    AUD_BCLK = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT = 1'b0;
    bus.sample_ready = 1'b1;
    bus.clear_overrun = 1'b0;
    #47;
    check("rst_left", bus.left_data, 0);
    check("rst_right", bus.right_data, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    #40 RST = 1'b1;

    // Stream starts mid-right word: nothing may come out before an aligned left word
    send_chan(1'b1, 16'($urandom), 16, 20, 1'($urandom));
    check("midright_valid", bus.sample_valid, 0);
    check_pairs("midright");

    send_frame(16'hA5C3, 16'h1234, 16, 32, 1'b1);
    expect_pair(16'hA5C3, 16'h1234, 16);
    check_pairs("fixed");
    for (int k = 0; k < 3; k++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      send_frame(l, r, 16, 32, 1'($urandom));
      expect_pair(l, r, 16);
      check_pairs("rand_full");
    end
    check("full_valid_low", bus.sample_valid, 0);

    // Backpressure: first pair is held, second is dropped with clear_overrun high
    set_ready(1'b0);
    send_frame(16'h0001, 16'h0002, 16, 32, 1'b1);
    check("bp_valid", bus.sample_valid, 1);
    check("bp_left", bus.left_data, 16'h0001);
    check("bp_right", bus.right_data, 16'h0002);
    check("bp_overrun0", bus.overrun, 0);
    found = 1'b0;
    bus.clear_overrun = 1'b1;
    fork
      send_frame(16'h0003, 16'h0004, 16, 32, 1'b0);
      begin
        for (int k = 0; k < 4000 && !found; k++) begin
          @(negedge CLOCK_50);
          if (bus.overrun) begin
            bus.clear_overrun = 1'b0;
            found = 1'b1;
          end
        end
      end
    join
    bus.clear_overrun = 1'b0;
    check("drop_overrun_rise", found, 1);
    idle(3);
    check("drop_overrun", bus.overrun, 1);
    check("drop_left", bus.left_data, 16'h0001);
    check("drop_right", bus.right_data, 16'h0002);
    check("drop_valid", bus.sample_valid, 1);
    check_pairs("drop_none");
    set_ready(1'b1);
    idle(3);
    expect_pair(16'h0001, 16'h0002, 16);
    check_pairs("bp_release");
    check("bp_valid_clear", bus.sample_valid, 0);
    l = 16'($urandom);
    r = 16'($urandom);
    send_frame(l, r, 16, 32, 1'($urandom));
    expect_pair(l, r, 16);
    check_pairs("bp_next");
    check("overrun_sticky", bus.overrun, 1);
    @(posedge CLOCK_50);
    #2 bus.clear_overrun = 1'b1;
    @(posedge CLOCK_50);
    #2 bus.clear_overrun = 1'b0;
    check("overrun_cleared", bus.overrun, 0);

    // Short 12-bit slots; the right word completes on the next frame's LRCK fall
    send_frame(16'h0ABC, 16'h0123, 12, 13, 1'b1);
    expect_pair(16'h0ABC, 16'h0123, 12);
    l = 16'($urandom);
    r = 16'($urandom);
    send_frame(l, r, 16, 32, 1'b0);
    expect_pair(l, r, 16);
    check_pairs("short_fixed");
    for (int k = 0; k < 2; k++) begin
      l = {4'h0, 12'($urandom)};
      r = {4'h0, 12'($urandom)};
      send_frame(l, r, 12, 13, 1'($urandom));
      expect_pair(l, r, 12);
      l = 16'($urandom);
      r = 16'($urandom);
      send_frame(l, r, 16, 32, 1'($urandom));
      expect_pair(l, r, 16);
      check_pairs("short_rand");
    end

    // Reset mid-left word with a pair held
    set_ready(1'b0);
    send_frame(16'($urandom), 16'($urandom), 16, 32, 1'b1);
    check("pre_rst_valid", bus.sample_valid, 1);
    send_chan(1'b0, 16'($urandom), 16, 9, 1'b0);
    @(posedge CLOCK_50);
    #5 RST = 1'b0;
    #1;
    check("mid_rst_left", bus.left_data, 0);
    check("mid_rst_right", bus.right_data, 0);
    check("mid_rst_valid", bus.sample_valid, 0);
    #20 RST = 1'b1;
    set_ready(1'b1);
    send_chan(1'b0, 16'($urandom), 16, 10, 1'b1);
    send_chan(1'b1, 16'($urandom), 16, 32, 1'b1);
    check("post_rst_valid", bus.sample_valid, 0);
    l = 16'($urandom);
    r = 16'($urandom);
    send_frame(l, r, 16, 32, 1'($urandom));
    expect_pair(l, r, 16);
    check_pairs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
